// File: rtl/radix5_pkg.sv
// Shared types and constants for the radix-5 group sequencer:
// FSM state encoding, pair beat indices and a complex sample type.
package radix5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE0 = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic PAIR_LO = 1'b0;
  localparam logic PAIR_HI = 1'b1;

  localparam int CPLX_DW = 32;

  typedef struct packed {
    logic [CPLX_DW-1:0] re;
    logic [CPLX_DW-1:0] img;
  } cplx_t;

endpackage

// File: rtl/radix5_tag_pipe.sv
// Fixed-latency shift register carrying {valid, group, pair} tags alongside
// the radix-5 datapath; the valid bit is the MSB of each tag.
module radix5_tag_pipe
#(
  parameter int DEPTH = 11,
  parameter int TW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] tag_in,
  output logic [TW-1:0] tag_out,
  output logic          any_valid
);

  logic [TW-1:0] stage_r [DEPTH];

  // Tag shift register, cleared by reset so in-flight tags are discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {TW{1'b0}};
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign tag_out = stage_r[DEPTH-1];

  // Valid entries still behind the output stage; the tag currently on the
  // output is excluded so the drain can finish as the last result appears
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) any_valid = any_valid | stage_r[i][TW-1];
  end

endmodule

// File: rtl/radix5_group_ctrl.sv
// Radix-5 group sequencer: packs samples into 5-point groups and issues
// (x1,x4) then (x2,x3) pair beats. Optional sticky err output: RADIX5_CTRL_ERR_EN.
module radix5_group_ctrl
  import radix5_pkg::*;
#(
  parameter int DW         = 32,
  parameter int GROUPS     = 5,
  parameter int DP_LATENCY = 11,
  parameter int GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic          in_ready,
  output logic          dp_issue,
  output logic [DW-1:0] dp_d_re,
  output logic [DW-1:0] dp_d_img,
  output logic [DW-1:0] dp_e_re,
  output logic [DW-1:0] dp_e_img,
  output logic [DW-1:0] dp_x0_re,
  output logic [DW-1:0] dp_x0_img,
  output logic          dp_pair,
  output logic          res_valid,
  output logic [GW-1:0] res_group,
  output logic          res_pair,
  output logic          busy,
  output logic          done
`ifdef RADIX5_CTRL_ERR_EN
  ,
  output logic          err
`endif
);

  localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS - 1);
  localparam int            TW         = GW + 2;

  state_t          state_r, state_s;
  logic [2:0]      sample_cnt_r;
  logic [GW-1:0]   group_cnt_r;
  logic [DW-1:0]   slot_re_r  [5];
  logic [DW-1:0]   slot_img_r [5];
  logic [TW-1:0]   tag_in_s, tag_out_s;
  logic            any_valid_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (start) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD:   if (in_valid && sample_cnt_r == 3'd4) state_s = ST_ISSUE0; else state_s = ST_LOAD;
      ST_ISSUE0: state_s = ST_ISSUE1;
      ST_ISSUE1: if (group_cnt_r == LAST_GROUP) state_s = ST_DRAIN; else state_s = ST_LOAD;
      ST_DRAIN:  if (!any_valid_s) state_s = ST_DONE; else state_s = ST_DRAIN;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Sample bank, sample counter and group counter; bank holds during issue
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_r <= 3'd0;
      group_cnt_r  <= GW'(0);
      for (int i = 0; i < 5; i++) begin
        slot_re_r[i]  <= {DW{1'b0}};
        slot_img_r[i] <= {DW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sample_cnt_r <= 3'd0;
            group_cnt_r  <= GW'(0);
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            slot_re_r[sample_cnt_r]  <= in_re;
            slot_img_r[sample_cnt_r] <= in_img;
            sample_cnt_r <= (sample_cnt_r == 3'd4) ? 3'd0 : sample_cnt_r + 3'd1;
          end
        end
        ST_ISSUE1: begin
          if (group_cnt_r != LAST_GROUP) group_cnt_r <= group_cnt_r + GW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from the registered state and sample bank
  always_comb begin
    in_ready = 1'b0;
    dp_issue = 1'b0;
    dp_pair  = PAIR_LO;
    dp_d_re  = {DW{1'b0}};
    dp_d_img = {DW{1'b0}};
    dp_e_re  = {DW{1'b0}};
    dp_e_img = {DW{1'b0}};
    done     = 1'b0;
    busy     = (state_r != ST_IDLE);
    case (state_r)
      ST_LOAD: in_ready = 1'b1;
      ST_ISSUE0: begin
        dp_issue = 1'b1;
        dp_pair  = PAIR_LO;
        dp_d_re  = slot_re_r[1];
        dp_d_img = slot_img_r[1];
        dp_e_re  = slot_re_r[4];
        dp_e_img = slot_img_r[4];
      end
      ST_ISSUE1: begin
        dp_issue = 1'b1;
        dp_pair  = PAIR_HI;
        dp_d_re  = slot_re_r[2];
        dp_d_img = slot_img_r[2];
        dp_e_re  = slot_re_r[3];
        dp_e_img = slot_img_r[3];
      end
      ST_DONE: done = 1'b1;
      default: begin
      end
    endcase
  end

  assign dp_x0_re  = slot_re_r[0];
  assign dp_x0_img = slot_img_r[0];

  // Idle cycles enter the pipe as all-zero tags so res_* stay 0 between results
  assign tag_in_s = dp_issue ? {1'b1, group_cnt_r, dp_pair} : {TW{1'b0}};

  radix5_tag_pipe #(
    .DEPTH (DP_LATENCY),
    .TW    (TW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_in_s),
    .tag_out   (tag_out_s),
    .any_valid (any_valid_s)
  );

  assign res_valid = tag_out_s[TW-1];
  assign res_group = tag_out_s[1 +: GW];
  assign res_pair  = tag_out_s[0];

`ifdef RADIX5_CTRL_ERR_EN
  logic err_r;

  // Sticky protocol error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((start && state_r != ST_IDLE) ||
                 (in_valid && (state_r == ST_ISSUE0 || state_r == ST_ISSUE1 ||
                               state_r == ST_DRAIN))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

endmodule
